// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and receiver/transmitter state encodings.
package uart_pkg;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned N_TICKS_DEF = 16;
  localparam int unsigned N_STOP_DEF  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch rejection, LSB-first data, stop-bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned N_TICKS = N_TICKS_DEF,
  parameter int unsigned N_STOP  = N_STOP_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx,
  input  logic               i_tick,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int unsigned TW = $clog2(N_TICKS);
  localparam int unsigned BW = $clog2(NB_DATA) + 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(N_TICKS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(N_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(N_STOP - 1);

  uart_state_e        state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;
  logic               rx;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_rx),
    .q   (rx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  // In STOP the bit counter counts stop bits; only the last stop bit is checked.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (i_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx, shift_q[NB_DATA-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (bit_q == STOP_LAST) begin
              state_d = IDLE;
              bit_d   = '0;
              if (rx) begin
                data_d = shift_q;
                done_d = 1'b1;
              end else begin
                ferr_d = 1'b1;
              end
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and randomized serial frames against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned NB       = 8;
  localparam int unsigned NT       = 16;
  localparam int unsigned TICK_DIV = 10;
  localparam int unsigned BIT_CLKS = NT * TICK_DIV;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          rx   = 1'b1;
  logic          tick = 1'b0;
  logic [NB-1:0] data;
  logic          done;
  logic          ferr;
  logic          busy;

  uart_rx #(.NB_DATA(NB), .N_TICKS(NT), .N_STOP(1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .i_tick      (tick),
    .o_data      (data),
    .o_rx_done   (done),
    .o_frame_err (ferr),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned tick_cnt = 0;
  always @(posedge clk) begin
    tick_cnt <= (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
    tick     <= (tick_cnt == TICK_DIV - 1);
  end

  // Reference model: frames expected to complete, last good byte, pulse totals.
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] exp_last = '0;
  int exp_done = 0;
  int exp_ferr = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int n_tests  = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
      prev_ferr = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        check("done_ferr_excl", 32'(ferr), 32'd0);
        check("done_width", 32'(prev_done), 32'd0);
        check("done_pending", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          exp_last = exp_q.pop_front();
          check("done_data", 32'(data), 32'(exp_last));
        end
      end
      if (ferr) begin
        ferr_cnt++;
        check("ferr_width", 32'(prev_ferr), 32'd0);
        check("ferr_keeps_data", 32'(data), 32'(exp_last));
      end
      prev_done = done;
      prev_ferr = ferr;
    end
  end

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // Noisy bits carry the real value only in the middle half of the bit period.
  task automatic drive_bit(input logic v, input bit noisy);
    for (int c = 0; c < int'(BIT_CLKS); c++) begin
      if (noisy && (c < 40 || c >= 120)) rx = 1'($urandom);
      else rx = v;
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [NB-1:0] d, input bit stop_ok, input bit noisy);
    if (stop_ok) begin
      exp_q.push_back(d);
      exp_done++;
    end else begin
      exp_ferr++;
    end
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < int'(NB); i++) drive_bit(d[i], noisy);
    if (stop_ok) begin
      drive_bit(1'b1, 1'b0);
    end else begin
      rx = 1'b0;
      repeat (120) @(posedge clk);
      idle(2 * BIT_CLKS + 40);
    end
  endtask

  task automatic scenario_check(input string tag);
    idle(BIT_CLKS);
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_data"}, 32'(data), 32'(exp_last));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_ferr_cnt"}, 32'(ferr_cnt), 32'(exp_ferr));
  endtask

  initial begin
    #12;
    check("rst_data", 32'(data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(50);

    send_frame(8'hA5, 1'b1, 1'b0);
    scenario_check("a5");

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    scenario_check("b2b");

    rx = 1'b0;
    repeat (4 * TICK_DIV) @(posedge clk);
    idle(2 * BIT_CLKS);
    scenario_check("glitch");

    send_frame(8'h3C, 1'b0, 1'b0);
    scenario_check("badstop");

    // Abort frame 0x5A partway through data bit 3.
    begin
      logic [NB-1:0] ab;
      ab = 8'h5A;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(ab[i], 1'b0);
      rx = ab[3];
      repeat (60) @(posedge clk);
    end
    @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ferr", 32'(ferr), 32'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_last = '0;
    idle(BIT_CLKS);
    send_frame(8'h81, 1'b1, 1'b0);
    scenario_check("after_rst");

    for (int k = 0; k < 4; k++) send_frame(8'($urandom), 1'b1, 1'b1);
    scenario_check("noisy");

    for (int k = 0; k < 12; k++) begin
      bit ok;
      bit nz;
      ok = ($urandom_range(0, 4) != 0);
      nz = 1'($urandom);
      send_frame(8'($urandom), ok, nz);
      idle($urandom_range(0, 2) * BIT_CLKS);
    end
    scenario_check("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL expose parameter NB_DATA, default 8, data bits per frame.
REQ-002 The block SHALL expose parameter N_TICKS, default 16, oversampling ticks per bit; legal values are even and at least 8.
REQ-003 The block SHALL expose parameter N_STOP, default 1, stop bits per frame; legal values are 1 and 2.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port i_rx, input, 1 bit: serial line, asynchronous to i_clk, idle high.
REQ-007 The block SHALL have port i_tick, input, 1 bit: one-cycle oversampling strobe at N_TICKS x baud rate.
REQ-008 The block SHALL have port o_data, output, NB_DATA bits: last correctly framed byte.
REQ-009 The block SHALL have port o_rx_done, output, 1 bit: one-cycle pulse when o_data is newly valid; drives the FIFO write strobe directly.
REQ-010 The block SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 i_rx SHALL pass through a two-flop synchronizer; all decisions use the synchronized value only (2-cycle input latency).
REQ-013 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-014 IDLE SHALL move to START on synchronized rx = 0, regardless of i_tick, and clear the tick counter.
REQ-015 The tick counter SHALL advance only on cycles with i_tick = 1.
REQ-016 START SHALL sample rx on the tick where the count reaches N_TICKS/2-1 (mid start bit).
REQ-017 At that START sample, rx = 0 SHALL move to DATA with both counters cleared; rx = 1 SHALL return to IDLE with no output pulse (glitch rejection).
REQ-018 DATA SHALL sample rx on every tick where the count reaches N_TICKS-1, then clear the tick counter.
REQ-019 Each DATA sample SHALL shift into the shift register LSB first.
REQ-020 After the NB_DATA-th DATA sample, DATA SHALL move to STOP.
REQ-021 STOP SHALL sample rx after N_STOP x N_TICKS ticks; with N_STOP = 2, only the final sample is checked.
REQ-022 A STOP sample of rx = 1 SHALL load o_data from the shift register and pulse o_rx_done on the next cycle.
REQ-023 A STOP sample of rx = 0 SHALL pulse o_frame_err on the next cycle, leave o_data unchanged, and suppress o_rx_done.
REQ-024 STOP SHALL return to IDLE immediately after its sample, whatever the sampled value.
REQ-025 A new falling edge SHALL be accepted in the first cycle after the return to IDLE, so back-to-back frames lose no data.
REQ-026 o_rx_done and o_frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one i_clk cycle.
REQ-027 The block SHALL have no backpressure input; FIFO overflow handling belongs to the FIFO.
REQ-028 The tick counter width SHALL be $clog2(N_TICKS) and SHALL wrap to 0 after N_TICKS-1.
REQ-029 The bit counter width SHALL be $clog2(NB_DATA) + 1.

Reset
REQ-030 Assertion of i_rst SHALL immediately force, without waiting for a clock edge: state = IDLE, both counters = 0, shift register = 0, o_data = 0, o_rx_done = 0, o_frame_err = 0, o_busy = 0, synchronizer flops = 1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait for the next falling edge.

Structure
REQ-032 State encodings and the default NB_DATA and N_TICKS values SHALL reside in shared package uart_pkg, which the transmitter also uses.
REQ-033 The synchronizer SHALL be sub-module sync_2ff with a parameterized reset value; no other sub-modules are permitted.

Verification (NB_DATA=8, N_TICKS=16, N_STOP=1, i_tick every 10 clocks)
REQ-034 Frame 0xA5 with a valid stop bit -> o_data = 0xA5 and exactly one o_rx_done pulse; o_frame_err stays 0.
REQ-035 Frames 0x00 then 0xFF back-to-back with no idle gap -> two o_rx_done pulses carrying 0x00 then 0xFF.
REQ-036 rx low for 4 ticks, then high -> return to IDLE, no pulses, o_data unchanged.
REQ-037 Frame 0x3C with stop bit = 0 -> single o_frame_err pulse, no o_rx_done, o_data keeps its previous value.
REQ-038 i_rst pulsed during data bit 3 of frame 0x5A, then a clean frame 0x81 -> all outputs 0 during reset, then o_data = 0x81 with one o_rx_done pulse.
REQ-039 Data bits toggled between tick samples -> only the mid-bit values appear in o_data.
